// File: rtl/zda_pkg.sv
// Shared constants, field layout and FSM encoding for the ZDA time decoder.
// The payload layout is ",hhmmss.cc,dd,mm,yyyy," with the leading comma at position 0.
package zda_pkg;

    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int IDX_W = 5;

    // Separator and field-start positions within the payload.
    localparam logic [IDX_W-1:0] POS_FIRST = 5'd1;
    localparam logic [IDX_W-1:0] POS_DOT   = 5'd7;
    localparam logic [IDX_W-1:0] POS_SEP1  = 5'd10;
    localparam logic [IDX_W-1:0] POS_SEP2  = 5'd13;
    localparam logic [IDX_W-1:0] POS_SEP3  = 5'd16;
    localparam logic [IDX_W-1:0] POS_HH    = 5'd1;
    localparam logic [IDX_W-1:0] POS_MI    = 5'd3;
    localparam logic [IDX_W-1:0] POS_SS    = 5'd5;
    localparam logic [IDX_W-1:0] POS_CC    = 5'd8;
    localparam logic [IDX_W-1:0] POS_DD    = 5'd11;
    localparam logic [IDX_W-1:0] POS_MO    = 5'd14;
    localparam logic [IDX_W-1:0] POS_YY    = 5'd17;

    localparam int HOURS_W    = 5;
    localparam int MIN_W      = 6;
    localparam int SEC_W      = 6;
    localparam int CS_W       = 7;
    localparam int DAY_W      = 5;
    localparam int MON_W      = 4;
    localparam int YEAR_W     = 12;
    localparam int SOD_W      = 17;
    localparam int SHADOW_W   = 7;
    localparam int ACC_CALC_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_SOD1,
        ST_SOD2,
        ST_OUT,
        ST_DRAIN
    } state_t;

    typedef enum logic [2:0] {
        FLD_NONE,
        FLD_HH,
        FLD_MI,
        FLD_SS,
        FLD_CC,
        FLD_DD,
        FLD_MO,
        FLD_YY
    } field_t;

    function automatic field_t fieldAt(input logic [IDX_W-1:0] idx);
        field_t f;
        f = FLD_NONE;
        if (idx == POS_HH || idx == POS_HH + 5'd1)      f = FLD_HH;
        else if (idx == POS_MI || idx == POS_MI + 5'd1) f = FLD_MI;
        else if (idx == POS_SS || idx == POS_SS + 5'd1) f = FLD_SS;
        else if (idx == POS_CC || idx == POS_CC + 5'd1) f = FLD_CC;
        else if (idx == POS_DD || idx == POS_DD + 5'd1) f = FLD_DD;
        else if (idx == POS_MO || idx == POS_MO + 5'd1) f = FLD_MO;
        else if (idx >= POS_YY && idx <= POS_YY + 5'd3) f = FLD_YY;
        return f;
    endfunction

    // Decimal accumulate acc*10+d built from shifts so no multiplier is inferred.
    function automatic logic [ACC_CALC_W-1:0] mulAdd10(input logic [ACC_CALC_W-1:0] acc,
                                                      input logic [3:0] d);
        return (acc << 3) + (acc << 1) + ACC_CALC_W'(d);
    endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII digit decoder: flags '0'..'9' and returns its numeric value.
module ascii_digit_decode
    import zda_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [3:0] o_value,
    output logic       o_isDigit
);

    // The low nibble of an ASCII digit is already its value.
    assign o_isDigit = (i_char >= ASCII_ZERO) && (i_char <= ASCII_ZERO + 8'd9);
    assign o_value   = i_char[3:0];

endmodule

// File: rtl/zda_time_decoder.sv
// Parses the ZDA payload character stream, range-checks the fields and presents one
// registered timestamp (with seconds-of-day) per accepted sentence.
module zda_time_decoder
    import zda_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int INFO_SIZE = 22,
    parameter int GAP_CHARS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic [4:0]  hours,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic [6:0]  centisec,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [11:0] year,
    output logic [16:0] sod,
    output logic        time_valid,
    output logic        fmt_err,
    output logic        busy
);

    // 64-bit arithmetic: the product overflows 32 bits at the default clock rate.
    localparam longint GAP_CYC = (longint'(GAP_CHARS) * 10 * longint'(CLK_FREQ)) / longint'(BAUD_RATE);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INFO_SIZE - 1);

    state_t r_state;
    state_t w_nextState;

    logic [IDX_W-1:0]    r_idx;
    logic [GAP_W-1:0]    r_gapCnt;
    logic [SHADOW_W-1:0] r_shHours;
    logic [SHADOW_W-1:0] r_shMinutes;
    logic [SHADOW_W-1:0] r_shSeconds;
    logic [SHADOW_W-1:0] r_shCentisec;
    logic [SHADOW_W-1:0] r_shDay;
    logic [SHADOW_W-1:0] r_shMonth;
    logic [YEAR_W-1:0]   r_shYear;
    logic [SOD_W-1:0]    r_sodAcc;

    logic [HOURS_W-1:0] r_hours;
    logic [MIN_W-1:0]   r_minutes;
    logic [SEC_W-1:0]   r_seconds;
    logic [CS_W-1:0]    r_centisec;
    logic [DAY_W-1:0]   r_day;
    logic [MON_W-1:0]   r_month;
    logic [YEAR_W-1:0]  r_year;
    logic [SOD_W-1:0]   r_sod;
    logic               r_timeValid;
    logic               r_fmtErr;

    logic [3:0]       w_digitVal;
    logic             w_isDigit;
    logic             w_expectComma;
    logic             w_expectDot;
    logic             w_charOk;
    logic             w_accept;
    logic             w_start;
    logic             w_gapState;
    logic             w_gapExpired;
    logic             w_rangeOk;
    logic             w_fmtErrNext;
    field_t           w_field;
    logic [SOD_W-1:0] w_hrs17;
    logic [SOD_W-1:0] w_min17;
    logic [SOD_W-1:0] w_sec17;
    logic [SOD_W-1:0] w_sodHours;
    logic [SOD_W-1:0] w_sodFinal;

    ascii_digit_decode u_digit (
        .i_char    (char_in),
        .o_value   (w_digitVal),
        .o_isDigit (w_isDigit)
    );

    assign w_expectComma = (r_idx == POS_SEP1) || (r_idx == POS_SEP2) ||
                           (r_idx == POS_SEP3) || (r_idx == LAST_IDX);
    assign w_expectDot   = (r_idx == POS_DOT);
    assign w_charOk      = w_expectComma ? (char_in == ASCII_COMMA) :
                           w_expectDot   ? (char_in == ASCII_DOT)   : w_isDigit;
    assign w_accept      = (r_state == ST_COLLECT) && char_valid && w_charOk;
    assign w_start       = (r_state == ST_IDLE) && char_valid && (char_in == ASCII_COMMA);
    assign w_field       = fieldAt(r_idx);

    assign w_gapState    = (r_state == ST_COLLECT) || (r_state == ST_DRAIN);
    assign w_gapExpired  = w_gapState && !char_valid && (r_gapCnt == GAP_LAST);

    assign w_rangeOk = (r_shHours <= 7'd23) && (r_shMinutes <= 7'd59) &&
                       (r_shSeconds <= 7'd60) && (r_shCentisec <= 7'd99) &&
                       (r_shDay >= 7'd1) && (r_shDay <= 7'd31) &&
                       (r_shMonth >= 7'd1) && (r_shMonth <= 7'd12);

    // hours*3600 = h*(2048+1024+512+16); minutes*60 = m*(64-4).
    assign w_hrs17    = SOD_W'(r_shHours);
    assign w_min17    = SOD_W'(r_shMinutes);
    assign w_sec17    = SOD_W'(r_shSeconds);
    assign w_sodHours = (w_hrs17 << 11) + (w_hrs17 << 10) + (w_hrs17 << 9) + (w_hrs17 << 4);
    assign w_sodFinal = r_sodAcc + (w_min17 << 6) - (w_min17 << 2) + w_sec17;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state decode; fmt_err is decided here and registered one cycle later.
    always_comb begin
        w_nextState  = r_state;
        w_fmtErrNext = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_nextState = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (char_valid) begin
                    if (!w_charOk) begin
                        w_nextState  = ST_DRAIN;
                        w_fmtErrNext = 1'b1;
                    end else if (r_idx == LAST_IDX) begin
                        w_nextState = ST_CHECK;
                    end
                end else if (w_gapExpired) begin
                    w_nextState  = ST_IDLE;
                    w_fmtErrNext = 1'b1;
                end
            end
            ST_CHECK: begin
                if (w_rangeOk) begin
                    w_nextState = ST_SOD1;
                end else begin
                    w_nextState  = ST_IDLE;
                    w_fmtErrNext = 1'b1;
                end
            end
            ST_SOD1:  w_nextState = ST_SOD2;
            ST_SOD2:  w_nextState = ST_OUT;
            ST_OUT:   w_nextState = ST_IDLE;
            ST_DRAIN: begin
                if (w_gapExpired) w_nextState = ST_IDLE;
            end
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Datapath; outputs load on the SOD2->OUT edge so they appear together with time_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_gapCnt     <= '0;
            r_shHours    <= '0;
            r_shMinutes  <= '0;
            r_shSeconds  <= '0;
            r_shCentisec <= '0;
            r_shDay      <= '0;
            r_shMonth    <= '0;
            r_shYear     <= '0;
            r_sodAcc     <= '0;
            r_hours      <= '0;
            r_minutes    <= '0;
            r_seconds    <= '0;
            r_centisec   <= '0;
            r_day        <= '0;
            r_month      <= '0;
            r_year       <= '0;
            r_sod        <= '0;
            r_timeValid  <= 1'b0;
            r_fmtErr     <= 1'b0;
        end else begin
            r_fmtErr    <= w_fmtErrNext;
            r_timeValid <= (r_state == ST_SOD2);
            r_gapCnt    <= (w_gapState && !char_valid && !w_gapExpired) ? r_gapCnt + GAP_W'(1) : '0;

            if (w_start) begin
                r_idx        <= POS_FIRST;
                r_shHours    <= '0;
                r_shMinutes  <= '0;
                r_shSeconds  <= '0;
                r_shCentisec <= '0;
                r_shDay      <= '0;
                r_shMonth    <= '0;
                r_shYear     <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + 5'd1;
                case (w_field)
                    FLD_HH:  r_shHours    <= SHADOW_W'(mulAdd10(ACC_CALC_W'(r_shHours), w_digitVal));
                    FLD_MI:  r_shMinutes  <= SHADOW_W'(mulAdd10(ACC_CALC_W'(r_shMinutes), w_digitVal));
                    FLD_SS:  r_shSeconds  <= SHADOW_W'(mulAdd10(ACC_CALC_W'(r_shSeconds), w_digitVal));
                    FLD_CC:  r_shCentisec <= SHADOW_W'(mulAdd10(ACC_CALC_W'(r_shCentisec), w_digitVal));
                    FLD_DD:  r_shDay      <= SHADOW_W'(mulAdd10(ACC_CALC_W'(r_shDay), w_digitVal));
                    FLD_MO:  r_shMonth    <= SHADOW_W'(mulAdd10(ACC_CALC_W'(r_shMonth), w_digitVal));
                    FLD_YY:  r_shYear     <= YEAR_W'(mulAdd10(ACC_CALC_W'(r_shYear), w_digitVal));
                    default: ;
                endcase
            end

            if (r_state == ST_SOD1) begin
                r_sodAcc <= w_sodHours;
            end

            if (r_state == ST_SOD2) begin
                r_sodAcc   <= w_sodFinal;
                r_sod      <= w_sodFinal;
                r_hours    <= r_shHours[HOURS_W-1:0];
                r_minutes  <= r_shMinutes[MIN_W-1:0];
                r_seconds  <= r_shSeconds[SEC_W-1:0];
                r_centisec <= r_shCentisec[CS_W-1:0];
                r_day      <= r_shDay[DAY_W-1:0];
                r_month    <= r_shMonth[MON_W-1:0];
                r_year     <= r_shYear;
            end
        end
    end

    assign hours      = r_hours;
    assign minutes    = r_minutes;
    assign seconds    = r_seconds;
    assign centisec   = r_centisec;
    assign day        = r_day;
    assign month      = r_month;
    assign year       = r_year;
    assign sod        = r_sod;
    assign time_valid = r_timeValid;
    assign fmt_err    = r_fmtErr;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_zda_time_decoder.sv
// Self-checking bench for zda_time_decoder: constant vector table, hand-timed corner
// sequences and random sentences checked against a string-parsing reference model.
module tb_zda_time_decoder;

    localparam int CLK_FREQ  = 48000;
    localparam int BAUD_RATE = 9600;
    localparam int CHAR_CYC  = 10 * CLK_FREQ / BAUD_RATE;
    localparam int GAP_CYC   = 4 * 10 * CLK_FREQ / BAUD_RATE;
    localparam int GAP_WAIT  = GAP_CYC + 60;
    localparam int NV        = 10;
    localparam int NRAND     = 16;

    typedef struct {
        int tv;
        int fe;
        int h;
        int mi;
        int se;
        int cs;
        int dd;
        int mo;
        int yy;
        int sod;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_in;
    logic        char_valid;
    logic [4:0]  hours;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic [6:0]  centisec;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic [16:0] sod;
    logic        time_valid;
    logic        fmt_err;
    logic        busy;

    int nChecks   = 0;
    int nFail     = 0;
    int tvCount   = 0;
    int feCount   = 0;
    int bothCount = 0;

    string vecStr [NV];
    exp_t  vecExp [NV];
    exp_t  held;
    exp_t  zeroExp;
    logic [7:0] badChars [4];

    zda_time_decoder #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .INFO_SIZE (22),
        .GAP_CHARS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .centisec   (centisec),
        .day        (day),
        .month      (month),
        .year       (year),
        .sod        (sod),
        .time_valid (time_valid),
        .fmt_err    (fmt_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Pulse tallies sampled away from the active edge.
    always @(negedge clk) begin
        if (time_valid) tvCount++;
        if (fmt_err) feCount++;
        if (time_valid && fmt_err) bothCount++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkFields(input string tag, input exp_t e);
        checkOutput($sformatf("%s hours", tag), int'(hours), e.h);
        checkOutput($sformatf("%s minutes", tag), int'(minutes), e.mi);
        checkOutput($sformatf("%s seconds", tag), int'(seconds), e.se);
        checkOutput($sformatf("%s centisec", tag), int'(centisec), e.cs);
        checkOutput($sformatf("%s day", tag), int'(day), e.dd);
        checkOutput($sformatf("%s month", tag), int'(month), e.mo);
        checkOutput($sformatf("%s year", tag), int'(year), e.yy);
        checkOutput($sformatf("%s sod", tag), int'(sod), e.sod);
    endtask

    task automatic sendChar(input logic [7:0] c);
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic applyStimulus(input string s, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sendChar(s[i]);
            repeat (CHAR_CYC - 2) @(negedge clk);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic runSentence(input string s, input exp_t e, input string tag);
        int tv0;
        int fe0;
        tv0 = tvCount;
        fe0 = feCount;
        applyStimulus(s, 0, 21);
        repeat (GAP_WAIT) @(negedge clk);
        checkOutput($sformatf("%s time_valid pulses", tag), tvCount - tv0, e.tv);
        checkOutput($sformatf("%s fmt_err pulses", tag), feCount - fe0, e.fe);
        checkFields(tag, e);
        checkOutput($sformatf("%s busy idle", tag), int'(busy), 0);
    endtask

    function automatic int fieldVal(input string s, input int start, input int len);
        int v;
        v = 0;
        for (int i = 0; i < len; i++) v = v * 10 + (s[start + i] - 8'h30);
        return v;
    endfunction

    // Reference decode of a whole payload string; rejected sentences keep the held values.
    function automatic exp_t modelDecode(input string s, input exp_t prev);
        exp_t r;
        logic [7:0] c;
        int h, mi, se, cs, dd, mo, yy;
        r    = prev;
        r.tv = 0;
        r.fe = 1;
        for (int p = 0; p < 22; p++) begin
            c = s[p];
            if (p == 0 || p == 10 || p == 13 || p == 16 || p == 21) begin
                if (c != 8'h2C) return r;
            end else if (p == 7) begin
                if (c != 8'h2E) return r;
            end else if (c < 8'h30 || c > 8'h39) begin
                return r;
            end
        end
        h  = fieldVal(s, 1, 2);
        mi = fieldVal(s, 3, 2);
        se = fieldVal(s, 5, 2);
        cs = fieldVal(s, 8, 2);
        dd = fieldVal(s, 11, 2);
        mo = fieldVal(s, 14, 2);
        yy = fieldVal(s, 17, 4);
        if (h > 23 || mi > 59 || se > 60 || cs > 99 || dd < 1 || dd > 31 || mo < 1 || mo > 12)
            return r;
        r = '{1, 0, h, mi, se, cs, dd, mo, yy % 4096, h * 3600 + mi * 60 + se};
        return r;
    endfunction

    initial begin
        string s;
        int tv0;
        int fe0;
        int p;
        int h, mi, se, cs, dd, mo, yy;

        vecStr[0] = ",235960.99,31,12,2016,"; vecExp[0] = '{1, 0, 23, 59, 60, 99, 31, 12, 2016, 86400};
        vecStr[1] = ",245959.00,01,01,2021,"; vecExp[1] = '{0, 1, 23, 59, 60, 99, 31, 12, 2016, 86400};
        vecStr[2] = ",210935.00,13,11,2020,"; vecExp[2] = '{1, 0, 21, 9, 35, 0, 13, 11, 2020, 76175};
        vecStr[3] = ",236000.00,01,01,2000,"; vecExp[3] = '{0, 1, 21, 9, 35, 0, 13, 11, 2020, 76175};
        vecStr[4] = ",000000.00,01,01,0000,"; vecExp[4] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecStr[5] = ",120000.50,00,06,1999,"; vecExp[5] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        vecStr[6] = ",120000.50,15,13,1999,"; vecExp[6] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        vecStr[7] = ",235961.00,01,01,2000,"; vecExp[7] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        vecStr[8] = ",123456.78,31,01,4095,"; vecExp[8] = '{1, 0, 12, 34, 56, 78, 31, 1, 4095, 45296};
        vecStr[9] = ",210935,00,13,11,2020,"; vecExp[9] = '{0, 1, 12, 34, 56, 78, 31, 1, 4095, 45296};
        zeroExp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        badChars[0] = 8'h61;
        badChars[1] = 8'h3A;
        badChars[2] = 8'h2F;
        badChars[3] = 8'h2C;

        rst        = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkFields("reset", zeroExp);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset time_valid", int'(time_valid), 0);
        checkOutput("reset fmt_err", int'(fmt_err), 0);

        // Latency: time_valid must appear exactly four cycles after the last char's cycle.
        s  = ",210935.00,13,11,2020,";
        fe0 = feCount;
        applyStimulus(s, 0, 20);
        sendChar(s[21]);
        for (int k = 1; k <= 5; k++) begin
            checkOutput($sformatf("latency time_valid at T+%0d", k), int'(time_valid), (k == 4) ? 1 : 0);
            if (k == 4) checkFields("latency", '{1, 0, 21, 9, 35, 0, 13, 11, 2020, 76175});
            @(negedge clk);
        end
        checkOutput("latency fmt_err pulses", feCount - fe0, 0);
        held = '{0, 0, 21, 9, 35, 0, 13, 11, 2020, 76175};
        repeat (GAP_WAIT) @(negedge clk);

        // Bad digit: fmt_err right after the offending char, outputs untouched.
        s   = ",2a0935.00,13,11,2020,";
        tv0 = tvCount;
        fe0 = feCount;
        applyStimulus(s, 0, 1);
        sendChar(s[2]);
        checkOutput("bad char fmt_err next cycle", int'(fmt_err), 1);
        checkOutput("bad char busy in drain", int'(busy), 1);
        repeat (CHAR_CYC - 2) @(negedge clk);
        applyStimulus(s, 3, 21);
        repeat (GAP_WAIT) @(negedge clk);
        checkOutput("bad char fmt_err pulses", feCount - fe0, 1);
        checkOutput("bad char time_valid pulses", tvCount - tv0, 0);
        checkFields("bad char held", held);

        for (int i = 0; i < NV; i++) begin
            runSentence(vecStr[i], vecExp[i], $sformatf("vec%0d", i));
        end
        held = vecExp[NV - 1];

        // Partial sentence followed by silence longer than the gap timeout.
        s   = ",210935.00,13,11,2020,";
        tv0 = tvCount;
        fe0 = feCount;
        applyStimulus(s, 0, 9);
        repeat (GAP_CYC + 100) @(negedge clk);
        checkOutput("gap timeout fmt_err pulses", feCount - fe0, 1);
        checkOutput("gap timeout time_valid pulses", tvCount - tv0, 0);
        checkOutput("gap timeout busy", int'(busy), 0);
        held = '{1, 0, 12, 0, 0, 50, 15, 6, 1999, 43200};
        runSentence(",120000.50,15,06,1999,", held, "after gap");

        // Non-comma characters in IDLE are ignored without an error.
        fe0 = feCount;
        sendChar(8'h78);
        sendChar(8'h35);
        repeat (4) @(negedge clk);
        checkOutput("idle junk fmt_err pulses", feCount - fe0, 0);
        checkOutput("idle junk busy", int'(busy), 0);

        // Reset mid-sentence at idx 15.
        s = ",235960.99,31,12,2016,";
        applyStimulus(s, 0, 14);
        checkOutput("mid-sentence busy", int'(busy), 1);
        pulseReset();
        checkFields("mid reset", zeroExp);
        checkOutput("mid reset busy", int'(busy), 0);
        runSentence(s, vecExp[0], "after mid reset");

        // Reset landing on the SOD2->OUT edge suppresses the pending time_valid.
        s   = ",000000.00,01,01,0000,";
        tv0 = tvCount;
        applyStimulus(s, 0, 20);
        sendChar(s[21]);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("late reset time_valid pulses", tvCount - tv0, 0);
        checkFields("late reset", zeroExp);
        held = zeroExp;

        for (int n = 0; n < NRAND; n++) begin
            h  = $urandom_range(0, 25);
            mi = $urandom_range(0, 61);
            se = $urandom_range(0, 61);
            cs = $urandom_range(0, 99);
            dd = $urandom_range(0, 32);
            mo = $urandom_range(0, 13);
            yy = $urandom_range(0, 4095);
            s  = $sformatf(",%02d%02d%02d.%02d,%02d,%02d,%04d,", h, mi, se, cs, dd, mo, yy);
            if ($urandom_range(0, 4) == 0) begin
                p = $urandom_range(1, 21);
                if (p == 7 || p == 10 || p == 13 || p == 16 || p == 21) s.putc(p, 8'h35);
                else s.putc(p, badChars[$urandom_range(0, 3)]);
            end
            held = modelDecode(s, held);
            runSentence(s, held, $sformatf("rand%0d %s", n, s));
        end

        checkOutput("time_valid and fmt_err overlap cycles", bothCount, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
